mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Registered two-requester arbiter that shares the single external memory port between the instruction handler (RIH: fetches, operand loads) and the ALU (load/store results).
- Sits between both requesters and the memory interface; replaces the passive select-based mux.
- Decides grants itself with round-robin fairness, one outstanding transaction at a time, and a watchdog that times out when the memory never acks.

Parameters:
- ADDR_W, 32, address width for read and write addresses.
- DATA_W, 32, data width for write and read data.
- TIMEOUT, 64, cycles to wait for mem_ack before aborting; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rih_req_valid  in  1  RIH request; held high and stable until rih_ack.
- rih_rd_wr  in  1  0 => read, 1 => write.
- rih_rd_addr  in  ADDR_W  RIH read address.
- rih_wr_addr  in  ADDR_W  RIH write address.
- rih_wr_data  in  DATA_W  RIH write data.
- rih_ack  out  1  one-cycle completion pulse to RIH.
- rih_rd_data  out  DATA_W  read data, valid while rih_ack=1.
- alu_req_valid, alu_rd_wr, alu_rd_addr, alu_wr_addr, alu_wr_data  in  same widths  ALU request, same rules as RIH.
- alu_ack  out  1  one-cycle completion pulse to ALU.
- alu_rd_data  out  DATA_W  read data, valid while alu_ack=1.
- mem_req_valid  out  1  request to memory; held until mem_ack or timeout.
- mem_rd_wr  out  1  latched direction.
- mem_rd_addr  out  ADDR_W  latched read address.
- mem_wr_addr  out  ADDR_W  latched write address.
- mem_wr_data  out  DATA_W  latched write data.
- mem_rd_data  in  DATA_W  memory read data, sampled when mem_ack=1.
- mem_ack  in  1  memory completion pulse.
- grant_rih  out  1  high while the RIH transaction is in flight (BUSY or RESP).
- grant_alu  out  1  high while the ALU transaction is in flight.
- bus_err  out  1  sticky; set on any timeout.

Behaviour:
- Reset (reset=0, async): state=IDLE; last_grant=ALU, so RIH wins the first tie. All outputs 0, including data and address registers, bus_err and the watchdog counter.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, BUSY, RESP.

IDLE:
- No request: stay in IDLE, mem_req_valid=0.
- One request: grant it.
- Both requests: grant the requester that is not last_grant (round-robin).
- On grant, latch the winner's rd_wr, rd_addr, wr_addr and wr_data into the mem_* registers.
- On grant, set mem_req_valid=1, set the grant_* flag, update last_grant, clear the counter, and go to BUSY.
- Latency: request sampled at edge k gives mem_req_valid=1 during cycle k+1.

BUSY:
- mem_* outputs held stable; requester inputs are ignored (re-latching is forbidden).
- mem_ack=1: mem_req_valid<=0, capture mem_rd_data into the granted requester's rd_data, pulse its ack during the next cycle, go to RESP.
- No ack: counter+1.
- TIMEOUT!=0 and counter==TIMEOUT-1 without ack: mem_req_valid<=0, bus_err<=1, granted rd_data<=0, pulse ack, go to RESP.
- Timed-out transactions complete so that requesters never hang.

RESP:
- Exactly one cycle with ack=1 for the granted requester; the other ack stays 0.
- No arbitration in this state; it lets the requester drop req_valid.
- At the next edge: ack<=0, grant_*<=0, go to IDLE.

Throughput and errors:
- Minimum transaction is 3 cycles (grant, ack sampled, RESP).
- Back-to-back requests from the same requester are allowed; each new request is arbitrated afresh in IDLE.
- mem_ack while in IDLE or RESP (spurious): ignored; no state change.
- The rd_data register of a requester keeps its last value outside its ack cycle; only reads have meaningful rd_data, and write acks return the mem_rd_data sampled.
- bus_err clears only on reset.

Reset mid-transaction:
- Immediate return to IDLE with all outputs 0.
- No ack is issued for the aborted transaction; the requester must re-request after reset.

Test Plan:
- Single RIH read (addr 0x100), memory acks after 2 cycles with 0xCAFE_F00D -> mem_req_valid 1 cycle after request, mem_rd_addr=0x100, rih_ack 1-cycle pulse with rih_rd_data=0xCAFE_F00D, alu_ack stays 0.
- RIH and ALU both request in the same cycle, three rounds each -> grants alternate RIH, ALU, RIH, ALU...; each ack occurs exactly once per transaction.
- ALU write (wr_addr=0x200, wr_data=0x1234_5678) while RIH requests mid-transaction -> mem_* stays at ALU values until mem_ack; RIH is granted in the IDLE cycle after RESP.
- TIMEOUT=4, memory never acks -> mem_req_valid drops after 4 BUSY cycles, bus_err=1 sticky, requester gets an ack with rd_data=0, the next request still proceeds normally.
- Spurious mem_ack pulse in IDLE, then reset asserted during BUSY -> no ack emitted, all outputs 0 asynchronously, first post-reset tie goes to RIH.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single external memory port between the instruction handler
// (RIH) and the ALU. At most one transaction is in flight at a time. Ties are
// broken round-robin against the last granted requester, and a watchdog
// completes a transaction that memory never acknowledges so that neither
// requester can hang. Every output is driven from a flop.
//
// Parameters
//   ADDR_W   address width of read and write addresses
//   DATA_W   width of write and read data
//   TIMEOUT  BUSY cycles to wait for mem_ack before aborting (0 = no watchdog)
//   CNT_W    watchdog counter width, 2**CNT_W must exceed TIMEOUT
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   rih_req_valid/rd_wr/...    RIH request, held stable until rih_ack
//   rih_ack, rih_rd_data       one-cycle completion pulse and its read data
//   alu_req_valid/rd_wr/...    ALU request, same rules as RIH
//   alu_ack, alu_rd_data       one-cycle completion pulse and its read data
//   mem_req_valid/rd_wr/...    latched request towards memory
//   mem_rd_data, mem_ack       memory response
//   grant_rih, grant_alu       owner of the transaction in flight (BUSY/RESP)
//   bus_err                    sticky watchdog timeout flag, cleared by reset
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              rih_req_valid,
  input  logic              rih_rd_wr,
  input  logic [ADDR_W-1:0] rih_rd_addr,
  input  logic [ADDR_W-1:0] rih_wr_addr,
  input  logic [DATA_W-1:0] rih_wr_data,
  output logic              rih_ack,
  output logic [DATA_W-1:0] rih_rd_data,

  input  logic              alu_req_valid,
  input  logic              alu_rd_wr,
  input  logic [ADDR_W-1:0] alu_rd_addr,
  input  logic [ADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0] alu_wr_data,
  output logic              alu_ack,
  output logic [DATA_W-1:0] alu_rd_data,

  output logic              mem_req_valid,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_ack,

  output logic              grant_rih,
  output logic              grant_alu,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam bit               WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state, state_nxt;
  logic                last_alu, last_alu_nxt;   // 1: ALU was granted last
  logic [CNT_W-1:0]    cnt, cnt_nxt;

  logic                rih_ack_nxt, alu_ack_nxt;
  logic [DATA_W-1:0]   rih_rd_data_nxt, alu_rd_data_nxt;
  logic                mem_req_valid_nxt, mem_rd_wr_nxt;
  logic [ADDR_W-1:0]   mem_rd_addr_nxt, mem_wr_addr_nxt;
  logic [DATA_W-1:0]   mem_wr_data_nxt;
  logic                grant_rih_nxt, grant_alu_nxt, bus_err_nxt;

  // Round-robin: on a tie the requester that was not served last wins.
  logic pick_rih, pick_alu, timeout_hit;
  assign pick_rih    = rih_req_valid & (~alu_req_valid | last_alu);
  assign pick_alu    = alu_req_valid & (~rih_req_valid | ~last_alu);
  assign timeout_hit = WDOG_EN && (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_alu      <= 1'b1;   // RIH wins the first tie after reset
      cnt           <= '0;
      rih_ack       <= 1'b0;
      alu_ack       <= 1'b0;
      rih_rd_data   <= '0;
      alu_rd_data   <= '0;
      mem_req_valid <= 1'b0;
      mem_rd_wr     <= 1'b0;
      mem_rd_addr   <= '0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      grant_rih     <= 1'b0;
      grant_alu     <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_alu      <= last_alu_nxt;
      cnt           <= cnt_nxt;
      rih_ack       <= rih_ack_nxt;
      alu_ack       <= alu_ack_nxt;
      rih_rd_data   <= rih_rd_data_nxt;
      alu_rd_data   <= alu_rd_data_nxt;
      mem_req_valid <= mem_req_valid_nxt;
      mem_rd_wr     <= mem_rd_wr_nxt;
      mem_rd_addr   <= mem_rd_addr_nxt;
      mem_wr_addr   <= mem_wr_addr_nxt;
      mem_wr_data   <= mem_wr_data_nxt;
      grant_rih     <= grant_rih_nxt;
      grant_alu     <= grant_alu_nxt;
      bus_err       <= bus_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_rih || pick_alu)   state_nxt = BUSY;
      BUSY:    if (mem_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-value logic for the registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    last_alu_nxt      = last_alu;
    cnt_nxt           = cnt;
    rih_ack_nxt       = 1'b0;
    alu_ack_nxt       = 1'b0;
    rih_rd_data_nxt   = rih_rd_data;
    alu_rd_data_nxt   = alu_rd_data;
    mem_req_valid_nxt = mem_req_valid;
    mem_rd_wr_nxt     = mem_rd_wr;
    mem_rd_addr_nxt   = mem_rd_addr;
    mem_wr_addr_nxt   = mem_wr_addr;
    mem_wr_data_nxt   = mem_wr_data;
    grant_rih_nxt     = grant_rih;
    grant_alu_nxt     = grant_alu;
    bus_err_nxt       = bus_err;

    case (state)
      IDLE: begin
        if (pick_rih) begin
          mem_req_valid_nxt = 1'b1;
          mem_rd_wr_nxt     = rih_rd_wr;
          mem_rd_addr_nxt   = rih_rd_addr;
          mem_wr_addr_nxt   = rih_wr_addr;
          mem_wr_data_nxt   = rih_wr_data;
          grant_rih_nxt     = 1'b1;
          last_alu_nxt      = 1'b0;
          cnt_nxt           = '0;
        end else if (pick_alu) begin
          mem_req_valid_nxt = 1'b1;
          mem_rd_wr_nxt     = alu_rd_wr;
          mem_rd_addr_nxt   = alu_rd_addr;
          mem_wr_addr_nxt   = alu_wr_addr;
          mem_wr_data_nxt   = alu_wr_data;
          grant_alu_nxt     = 1'b1;
          last_alu_nxt      = 1'b1;
          cnt_nxt           = '0;
        end
      end

      BUSY: begin
        // A real ack takes priority over a watchdog expiring in the same cycle.
        if (mem_ack) begin
          mem_req_valid_nxt = 1'b0;
          if (grant_rih) begin
            rih_rd_data_nxt = mem_rd_data;
            rih_ack_nxt     = 1'b1;
          end else begin
            alu_rd_data_nxt = mem_rd_data;
            alu_ack_nxt     = 1'b1;
          end
        end else if (timeout_hit) begin
          // Complete the abandoned transaction with zero data so the
          // requester is released; the error is recorded in bus_err.
          mem_req_valid_nxt = 1'b0;
          bus_err_nxt       = 1'b1;
          if (grant_rih) begin
            rih_rd_data_nxt = '0;
            rih_ack_nxt     = 1'b1;
          end else begin
            alu_rd_data_nxt = '0;
            alu_ack_nxt     = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      RESP: begin
        grant_rih_nxt = 1'b0;
        grant_alu_nxt = 1'b0;
      end

      default: begin
        mem_req_valid_nxt = 1'b0;
        grant_rih_nxt     = 1'b0;
        grant_alu_nxt     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter built with TIMEOUT=4. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              rih_req_valid, rih_rd_wr;
  logic [ADDR_W-1:0] rih_rd_addr, rih_wr_addr;
  logic [DATA_W-1:0] rih_wr_data;
  logic              rih_ack;
  logic [DATA_W-1:0] rih_rd_data;
  logic              alu_req_valid, alu_rd_wr;
  logic [ADDR_W-1:0] alu_rd_addr, alu_wr_addr;
  logic [DATA_W-1:0] alu_wr_data;
  logic              alu_ack;
  logic [DATA_W-1:0] alu_rd_data;
  logic              mem_req_valid, mem_rd_wr;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_ack;
  logic              grant_rih, grant_alu, bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rih_req_valid(rih_req_valid),
    .rih_rd_wr    (rih_rd_wr),
    .rih_rd_addr  (rih_rd_addr),
    .rih_wr_addr  (rih_wr_addr),
    .rih_wr_data  (rih_wr_data),
    .rih_ack      (rih_ack),
    .rih_rd_data  (rih_rd_data),
    .alu_req_valid(alu_req_valid),
    .alu_rd_wr    (alu_rd_wr),
    .alu_rd_addr  (alu_rd_addr),
    .alu_wr_addr  (alu_wr_addr),
    .alu_wr_data  (alu_wr_data),
    .alu_ack      (alu_ack),
    .alu_rd_data  (alu_rd_data),
    .mem_req_valid(mem_req_valid),
    .mem_rd_wr    (mem_rd_wr),
    .mem_rd_addr  (mem_rd_addr),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .mem_ack      (mem_ack),
    .grant_rih    (grant_rih),
    .grant_alu    (grant_alu),
    .bus_err      (bus_err)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req_valid"}, mem_req_valid, 0);
    check({tag, " mem_rd_wr"},     mem_rd_wr,     0);
    check({tag, " mem_rd_addr"},   mem_rd_addr,   0);
    check({tag, " mem_wr_addr"},   mem_wr_addr,   0);
    check({tag, " mem_wr_data"},   mem_wr_data,   0);
    check({tag, " rih_ack"},       rih_ack,       0);
    check({tag, " alu_ack"},       alu_ack,       0);
    check({tag, " rih_rd_data"},   rih_rd_data,   0);
    check({tag, " alu_rd_data"},   alu_rd_data,   0);
    check({tag, " grant_rih"},     grant_rih,     0);
    check({tag, " grant_alu"},     grant_alu,     0);
    check({tag, " bus_err"},       bus_err,       0);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset         = 1'b0;
    rih_req_valid = 1'b0; rih_rd_wr = 1'b0;
    rih_rd_addr   = '0;   rih_wr_addr = '0; rih_wr_data = '0;
    alu_req_valid = 1'b0; alu_rd_wr = 1'b0;
    alu_rd_addr   = '0;   alu_wr_addr = '0; alu_wr_data = '0;
    mem_rd_data   = '0;   mem_ack = 1'b0;

    // ---- Reset state ---------------------------------------------------------
    step(); step();
    check_all_zero("reset");
    reset = 1'b1;
    step();
    check("idle mem_req_valid", mem_req_valid, 0);

    // ---- Single RIH read, memory acks on the second BUSY cycle ---------------
    rih_req_valid = 1'b1; rih_rd_wr = 1'b0;
    rih_rd_addr = 32'h100; rih_wr_addr = 32'hAAA; rih_wr_data = 32'h55;
    step();
    check("t1 mem_req_valid", mem_req_valid, 1);
    check("t1 mem_rd_addr",   mem_rd_addr,   32'h100);
    check("t1 mem_rd_wr",     mem_rd_wr,     0);
    check("t1 grant_rih",     grant_rih,     1);
    check("t1 grant_alu",     grant_alu,     0);
    check("t1 rih_ack busy",  rih_ack,       0);
    step();
    check("t1 still busy",    mem_req_valid, 1);
    mem_ack = 1'b1; mem_rd_data = 32'hCAFE_F00D;
    step();
    check("t1 rih_ack",       rih_ack,       1);
    check("t1 rih_rd_data",   rih_rd_data,   32'hCAFE_F00D);
    check("t1 alu_ack",       alu_ack,       0);
    check("t1 req dropped",   mem_req_valid, 0);
    mem_ack = 1'b0; rih_req_valid = 1'b0;
    step();
    check("t1 rih_ack pulse", rih_ack,       0);
    check("t1 grant cleared", grant_rih,     0);

    // ---- Simultaneous requests, three rounds each ----------------------------
    // RIH was served last, so the ALU takes the first tie.
    rih_rd_addr = 32'h300; alu_rd_addr = 32'h400; alu_rd_wr = 1'b0;
    rih_req_valid = 1'b1; alu_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic alu_wins;
      alu_wins = (i % 2 == 0);
      step();
      check("rr grant_alu", grant_alu, alu_wins);
      check("rr grant_rih", grant_rih, !alu_wins);
      check("rr mem_rd_addr", mem_rd_addr, alu_wins ? 32'h400 : 32'h300);
      mem_ack = 1'b1; mem_rd_data = 32'h1000 + i;
      step();
      check("rr alu_ack", alu_ack, alu_wins);
      check("rr rih_ack", rih_ack, !alu_wins);
      check("rr rd_data", alu_wins ? alu_rd_data : rih_rd_data, 32'h1000 + i);
      mem_ack = 1'b0;
      if (alu_wins) alu_req_valid = 1'b0; else rih_req_valid = 1'b0;
      step();
      check("rr acks idle", {rih_ack, alu_ack}, 2'b00);
      rih_req_valid = 1'b1; alu_req_valid = 1'b1;
    end
    rih_req_valid = 1'b0; alu_req_valid = 1'b0;

    // ---- ALU write with RIH arriving mid-transaction -------------------------
    alu_req_valid = 1'b1; alu_rd_wr = 1'b1; alu_rd_addr = 32'h0;
    alu_wr_addr = 32'h200; alu_wr_data = 32'h1234_5678;
    step();
    check("t3 grant_alu", grant_alu, 1);
    rih_req_valid = 1'b1; rih_rd_wr = 1'b0; rih_rd_addr = 32'h500;
    rih_wr_addr = 32'h9999; rih_wr_data = 32'h7777_7777;
    check("t3 mem_rd_wr",   mem_rd_wr,   1);
    check("t3 mem_wr_addr", mem_wr_addr, 32'h200);
    check("t3 mem_wr_data", mem_wr_data, 32'h1234_5678);
    step();
    check("t3 held wr_addr", mem_wr_addr, 32'h200);
    check("t3 held wr_data", mem_wr_data, 32'h1234_5678);
    check("t3 held rd_wr",   mem_rd_wr,   1);
    check("t3 no grant_rih", grant_rih,   0);
    mem_ack = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
    step();
    check("t3 alu_ack",      alu_ack,     1);
    check("t3 alu_rd_data",  alu_rd_data, 32'hDEAD_BEEF);
    check("t3 rih_ack",      rih_ack,     0);
    mem_ack = 1'b0; alu_req_valid = 1'b0;
    step();
    check("t3 idle no req",  mem_req_valid, 0);
    check("t3 idle grants",  {grant_rih, grant_alu}, 2'b00);
    step();
    check("t3 rih granted",  grant_rih,   1);
    check("t3 rih rd_addr",  mem_rd_addr, 32'h500);
    check("t3 rih rd_wr",    mem_rd_wr,   0);
    mem_ack = 1'b1; mem_rd_data = 32'h0BAD_F00D;
    step();
    check("t3 rih_ack",      rih_ack,     1);
    check("t3 rih_rd_data",  rih_rd_data, 32'h0BAD_F00D);
    mem_ack = 1'b0; rih_req_valid = 1'b0;
    step();

    // ---- Watchdog: memory never acks -----------------------------------------
    alu_req_valid = 1'b1; alu_rd_wr = 1'b0; alu_rd_addr = 32'h600;
    step();
    check("t4 busy1", mem_req_valid, 1);
    step();
    check("t4 busy2", mem_req_valid, 1);
    step();
    check("t4 busy3", mem_req_valid, 1);
    step();
    check("t4 busy4", mem_req_valid, 1);
    check("t4 no err yet", bus_err, 0);
    step();
    check("t4 req dropped", mem_req_valid, 0);
    check("t4 bus_err",     bus_err,       1);
    check("t4 alu_ack",     alu_ack,       1);
    check("t4 alu_rd_data", alu_rd_data,   0);
    alu_req_valid = 1'b0;
    step();
    check("t4 ack pulse",   alu_ack,       0);
    check("t4 err sticky",  bus_err,       1);
    rih_req_valid = 1'b1; rih_rd_addr = 32'h700;
    step();
    check("t4 next grant",  grant_rih,     1);
    check("t4 next addr",   mem_rd_addr,   32'h700);
    mem_ack = 1'b1; mem_rd_data = 32'h7777;
    step();
    check("t4 next ack",    rih_ack,       1);
    check("t4 next data",   rih_rd_data,   32'h7777);
    check("t4 err kept",    bus_err,       1);
    mem_ack = 1'b0; rih_req_valid = 1'b0;
    step();

    // ---- Spurious ack in IDLE, then reset during BUSY ------------------------
    mem_ack = 1'b1; mem_rd_data = 32'h5A5A_5A5A;
    step();
    check("t5 spur req",   mem_req_valid, 0);
    check("t5 spur acks",  {rih_ack, alu_ack}, 2'b00);
    check("t5 spur grant", {grant_rih, grant_alu}, 2'b00);
    check("t5 spur rih_d", rih_rd_data, 32'h7777);
    mem_ack = 1'b0;
    alu_req_valid = 1'b1; alu_rd_addr = 32'h800;
    step();
    check("t5 busy grant", grant_alu, 1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("t5 async reset");
    step();
    check("t5 no ack in reset", alu_ack, 0);
    reset = 1'b1;
    rih_req_valid = 1'b1; rih_rd_addr = 32'h900;
    step();
    check("t5 tie grant_rih", grant_rih, 1);
    check("t5 tie grant_alu", grant_alu, 0);
    check("t5 tie rd_addr",   mem_rd_addr, 32'h900);
    mem_ack = 1'b1; mem_rd_data = 32'h1111_2222;
    step();
    check("t5 rih_ack",       rih_ack, 1);
    check("t5 alu_ack",       alu_ack, 0);
    mem_ack = 1'b0; rih_req_valid = 1'b0; alu_req_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
